core_bus_scheduler: RTL and testbench

Sequences commands from instruction_handler onto the shared internal core bus. Decodes the 24-bit address into a core index and a local offset, then issues a one-cycle strobe to exactly one core_interface. Waits for that core's done, with a timeout, and returns a single result/response to instruction_handler. It is the only master on the core bus; cores never see overlapping commands.

---
 rtl/core_bus_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_core_bus_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_scheduler.sv
// core_bus_scheduler: sole master of the internal core bus. It decodes a global address, strobes one core, waits for done or timeout, and returns one response.
// Optional feature macro: CORE_BUS_STATS_EN (completion/timeout counters, read locally through opcode 0xFF).
module core_bus_scheduler #(
    parameter int NUM_CORES      = 2,
    parameter int CORE_SPAN_LOG2 = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_n,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [7:0]              instruction_i,
    input  logic [23:0]             address_i,
    input  logic [31:0]             value_i,
    output logic                    rsp_valid_o,
    output logic                    rsp_err_o,
    output logic [31:0]             result_o,
    output logic [NUM_CORES-1:0]    core_sel_o,
    output logic [7:0]              core_instruction_o,
    output logic [23:0]             core_address_o,
    output logic [31:0]             core_value_o,
    input  logic [NUM_CORES-1:0]    core_done_i,
    input  logic [32*NUM_CORES-1:0] core_result_i
);
    localparam int          IDX_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [23:0] OFFSET_MASK = (24'd1 << CORE_SPAN_LOG2) - 24'd1;
    localparam logic [23:0] NUM_CORES_L = 24'(NUM_CORES);
    localparam logic [16:0] TIMEOUT_L   = 17'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state_r;
    logic [IDX_W-1:0]     idx_r;
    logic [15:0]          cnt_r;
    logic                 ready_r;
    logic                 rsp_valid_r;
    logic                 rsp_err_r;
    logic [31:0]          result_r;
    logic [NUM_CORES-1:0] core_sel_r;
    logic [7:0]           core_instruction_r;
    logic [23:0]          core_address_r;
    logic [31:0]          core_value_r;

    logic [23:0]          addr_idx_s;
    logic                 mapped_s;
    logic [NUM_CORES-1:0] onehot_s;
    logic                 done_sel_s;
    logic [31:0]          res_sel_s;
    logic [16:0]          cnt_inc_s;
    logic                 timeout_hit_s;

    assign cmd_ready_o        = ready_r;
    assign rsp_valid_o        = rsp_valid_r;
    assign rsp_err_o          = rsp_err_r;
    assign result_o           = result_r;
    assign core_sel_o         = core_sel_r;
    assign core_instruction_o = core_instruction_r;
    assign core_address_o     = core_address_r;
    assign core_value_o       = core_value_r;

    // Full-width decode so addresses far above the mapped range never alias onto a core.
    always_comb begin
        addr_idx_s = address_i >> CORE_SPAN_LOG2;
        mapped_s   = (addr_idx_s < NUM_CORES_L);
        onehot_s   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (addr_idx_s == 24'(k)) begin
                onehot_s[k] = 1'b1;
            end else begin
                onehot_s[k] = 1'b0;
            end
        end
    end

    // Select the done bit and result slice of the core that owns the command in flight.
    always_comb begin
        done_sel_s = 1'b0;
        res_sel_s  = 32'h0000_0000;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (idx_r == IDX_W'(k)) begin
                done_sel_s = core_done_i[k];
                res_sel_s  = core_result_i[k*32 +: 32];
            end else begin
                done_sel_s = done_sel_s;
                res_sel_s  = res_sel_s;
            end
        end
    end

    // Wait-cycle count including the current cycle; reaching TIMEOUT ends the wait.
    always_comb begin
        cnt_inc_s     = {1'b0, cnt_r} + 17'd1;
        timeout_hit_s = (cnt_inc_s == TIMEOUT_L);
    end

`ifdef CORE_BUS_STATS_EN
    logic [15:0] completions_r;
    logic [15:0] timeouts_r;
    logic        done_evt_s;
    logic        tmo_evt_s;

    assign done_evt_s = (state_r == WAIT) && done_sel_s;
    assign tmo_evt_s  = (state_r == WAIT) && !done_sel_s && timeout_hit_s;

    // Saturating counters of done and timeout responses.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            completions_r <= 16'h0000;
            timeouts_r    <= 16'h0000;
        end else begin
            if (done_evt_s && (completions_r != 16'hFFFF)) begin
                completions_r <= completions_r + 16'd1;
            end else begin
                completions_r <= completions_r;
            end
            if (tmo_evt_s && (timeouts_r != 16'hFFFF)) begin
                timeouts_r <= timeouts_r + 16'd1;
            end else begin
                timeouts_r <= timeouts_r;
            end
        end
    end
`endif

    // Command sequencer; the bus fields change only when a command is issued.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_r            <= IDLE;
            idx_r              <= '0;
            cnt_r              <= 16'h0000;
            ready_r            <= 1'b1;
            rsp_valid_r        <= 1'b0;
            rsp_err_r          <= 1'b0;
            result_r           <= 32'h0000_0000;
            core_sel_r         <= '0;
            core_instruction_r <= 8'h00;
            core_address_r     <= 24'h000000;
            core_value_r       <= 32'h0000_0000;
        end else begin
            rsp_valid_r <= 1'b0;
            core_sel_r  <= '0;
            case (state_r)
                IDLE: begin
                    if (cmd_valid_i && ready_r) begin
                        ready_r <= 1'b0;
                        if (instruction_i == 8'h00) begin
                            result_r    <= 32'h0000_0000;
                            rsp_err_r   <= 1'b0;
                            rsp_valid_r <= 1'b1;
                            state_r     <= RESP;
`ifdef CORE_BUS_STATS_EN
                        end else if (instruction_i == 8'hFF) begin
                            result_r    <= {timeouts_r, completions_r};
                            rsp_err_r   <= 1'b0;
                            rsp_valid_r <= 1'b1;
                            state_r     <= RESP;
`endif
                        end else if (!mapped_s) begin
                            result_r    <= 32'h0000_0000;
                            rsp_err_r   <= 1'b1;
                            rsp_valid_r <= 1'b1;
                            state_r     <= RESP;
                        end else begin
                            idx_r              <= addr_idx_s[IDX_W-1:0];
                            core_sel_r         <= onehot_s;
                            core_instruction_r <= instruction_i;
                            core_address_r     <= address_i & OFFSET_MASK;
                            core_value_r       <= value_i;
                            state_r            <= ISSUE;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ISSUE: begin
                    cnt_r   <= 16'h0000;
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (done_sel_s) begin
                        result_r    <= res_sel_s;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end else if (timeout_hit_s) begin
                        result_r    <= 32'h0000_0000;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end else begin
                        cnt_r <= cnt_inc_s[15:0];
                    end
                end
                RESP: begin
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_bus_scheduler.sv
// Self-checking bench for core_bus_scheduler: directed scenarios plus random commands against a latency/response model.
module tb_core_bus_scheduler;
    localparam int NUM  = 2;
    localparam int SPAN = 4;
    localparam int TMO  = 255;

    logic              clk_i = 1'b0;
    logic              rst_n;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [7:0]        instruction_i;
    logic [23:0]       address_i;
    logic [31:0]       value_i;
    logic              rsp_valid_o;
    logic              rsp_err_o;
    logic [31:0]       result_o;
    logic [NUM-1:0]    core_sel_o;
    logic [7:0]        core_instruction_o;
    logic [23:0]       core_address_o;
    logic [31:0]       core_value_o;
    logic [NUM-1:0]    core_done_i;
    logic [32*NUM-1:0] core_result_i;

    core_bus_scheduler #(.NUM_CORES(NUM), .CORE_SPAN_LOG2(SPAN), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .instruction_i(instruction_i), .address_i(address_i), .value_i(value_i),
        .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .result_o(result_o),
        .core_sel_o(core_sel_o), .core_instruction_o(core_instruction_o),
        .core_address_o(core_address_o), .core_value_o(core_value_o),
        .core_done_i(core_done_i), .core_result_i(core_result_i)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    bit          stats_en;
    int          cmp_cnt;
    int          tmo_cnt;
    logic [7:0]  last_ins;
    logic [23:0] last_addr;
    logic [31:0] last_val;
    logic [31:0] dummy;

    task automatic model_reset();
        cmp_cnt = 0; tmo_cnt = 0;
        last_ins = 8'h00; last_addr = 24'h000000; last_val = 32'h0;
    endtask

    // Expected outcome from the rules: response cycle (accept edge = 0), error, result, strobe.
    task automatic predict(input logic [7:0] ins, input logic [23:0] addr, input int delay,
                           output int cyc, output logic err, output logic [31:0] res,
                           output logic [NUM-1:0] sel, output bit fwd);
        int idx;
        idx = int'(addr) >> SPAN;
        sel = '0; fwd = 1'b0; err = 1'b0; res = 32'h0; cyc = 1;
        if (ins == 8'h00) begin
            cyc = 1;
        end else if (stats_en && ins == 8'hFF) begin
            res = {tmo_cnt[15:0], cmp_cnt[15:0]};
        end else if (idx >= NUM) begin
            err = 1'b1;
        end else begin
            fwd = 1'b1;
            sel[idx] = 1'b1;
            if (delay >= 0 && delay < TMO) begin
                cyc = 3 + delay;
                res = core_result_i[idx*32 +: 32];
            end else begin
                cyc = TMO + 2;
                err = 1'b1;
            end
        end
    endtask

    // Issue one command at a negedge with the DUT idle; checks every cycle through the cycle after the response.
    task automatic run_cmd(input logic [7:0] ins, input logic [23:0] addr, input logic [31:0] val,
                           input int delay, input bit issue_noise, input bit hold,
                           output logic [31:0] got_res);
        int             cyc;
        logic           exp_err;
        logic [31:0]    exp_res;
        logic [NUM-1:0] exp_sel;
        logic [NUM-1:0] want_sel;
        logic [NUM-1:0] noise;
        bit             fwd;
        logic [7:0]     exp_ci;
        logic [23:0]    exp_ca;
        logic [31:0]    exp_cv;
        predict(ins, addr, delay, cyc, exp_err, exp_res, exp_sel, fwd);
        if (fwd) begin
            exp_ci = ins; exp_ca = 24'(int'(addr) % (1 << SPAN)); exp_cv = val;
        end else begin
            exp_ci = last_ins; exp_ca = last_addr; exp_cv = last_val;
        end
        got_res = 32'h0;
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++; $display("FAIL ready_before_cmd: got %b want 1", cmd_ready_o);
        end
        cmd_valid_i = 1'b1; instruction_i = ins; address_i = addr; value_i = val;
        for (int c = 1; c <= cyc + 1; c++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (hold && c <= cyc) begin
                instruction_i = 8'($urandom); address_i = 24'($urandom); value_i = $urandom;
            end else if (!hold) begin
                cmd_valid_i = 1'b0;
            end
            noise = NUM'($urandom);
            if (fwd) noise = noise & ~exp_sel;
            if (fwd && delay >= 0 && delay < TMO && c == 2 + delay) noise = noise | exp_sel;
            if (fwd && issue_noise && c == 1) noise = noise | exp_sel;
            core_done_i = noise;
            want_sel = (c == 1) ? exp_sel : '0;
            checks++;
            if (core_sel_o !== want_sel) begin
                errors++; $display("FAIL core_sel cyc%0d ins=%h addr=%h: got %b want %b", c, ins, addr, core_sel_o, want_sel);
            end
            checks++;
            if (rsp_valid_o !== (c == cyc)) begin
                errors++; $display("FAIL rsp_valid cyc%0d ins=%h addr=%h: got %b want %b", c, ins, addr, rsp_valid_o, (c == cyc));
            end
            checks++;
            if (cmd_ready_o !== (c > cyc)) begin
                errors++; $display("FAIL cmd_ready cyc%0d: got %b want %b", c, cmd_ready_o, (c > cyc));
            end
            if (c == 1) begin
                checks++;
                if ({core_instruction_o, core_address_o, core_value_o} !== {exp_ci, exp_ca, exp_cv}) begin
                    errors++; $display("FAIL core_fields: got %h/%h/%h want %h/%h/%h", core_instruction_o, core_address_o, core_value_o, exp_ci, exp_ca, exp_cv);
                end
            end
            if (c == cyc) begin
                got_res = result_o;
                checks++;
                if (rsp_err_o !== exp_err || result_o !== exp_res) begin
                    errors++; $display("FAIL response ins=%h addr=%h delay=%0d: got err=%b res=%h want err=%b res=%h", ins, addr, delay, rsp_err_o, result_o, exp_err, exp_res);
                end
            end
            if (c == cyc + 1) begin
                checks++;
                if (result_o !== exp_res) begin
                    errors++; $display("FAIL result_hold: got %h want %h", result_o, exp_res);
                end
            end
        end
        core_done_i = '0;
        last_ins = exp_ci; last_addr = exp_ca; last_val = exp_cv;
        if (fwd && exp_err && tmo_cnt < 65535) tmo_cnt++;
        if (fwd && !exp_err && cmp_cnt < 65535) cmp_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid_i = 1'b0; instruction_i = 8'h00; address_i = 24'h0; value_i = 32'h0;
        core_done_i = '0; core_result_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({cmd_ready_o, core_sel_o, rsp_valid_o} !== {1'b1, {NUM{1'b0}}, 1'b0}) begin
                errors++; $display("FAIL reset_idle cyc%0d: got ready=%b sel=%b rsp=%b want 1/0/0", i, cmd_ready_o, core_sel_o, rsp_valid_o);
            end
            @(posedge clk_i);
            @(negedge clk_i);
        end
        checks++;
        if ({result_o, rsp_err_o, core_instruction_o, core_address_o, core_value_o} !== 97'h0) begin
            errors++; $display("FAIL reset_values: got res=%h err=%b ci=%h ca=%h cv=%h want 0", result_o, rsp_err_o, core_instruction_o, core_address_o, core_value_o);
        end
    endtask

    task automatic test_mapped();
        logic [31:0] got;
        core_result_i = {32'h0000_0008, 32'hDEAD_BEEF};
        run_cmd(8'h01, 24'h000013, 32'h5, 2, 1'b1, 1'b0, got);
        checks++;
        if (got !== 32'h0000_0008) begin
            errors++; $display("FAIL mapped_core1_result: got %h want 00000008", got);
        end
    endtask

    task automatic test_unmapped();
        run_cmd(8'h01, 24'h000020, 32'h1234, 0, 1'b0, 1'b0, dummy);
        run_cmd(8'h07, 24'hFFFFFF, 32'h1, 0, 1'b0, 1'b0, dummy);
        run_cmd(8'h07, 24'h100003, 32'h2, 0, 1'b0, 1'b0, dummy);
        run_cmd(8'h00, 24'h000001, 32'h3, 0, 1'b0, 1'b0, dummy);
    endtask

    task automatic test_timeout();
        run_cmd(8'h02, 24'h000002, 32'hCAFE, -1, 1'b1, 1'b0, dummy);
    endtask

    task automatic test_stats();
        logic [31:0] got;
        core_result_i = {32'h1111_2222, 32'h3333_4444};
        run_cmd(8'hFF, 24'h000000, 32'h9, 0, 1'b0, 1'b0, got);
`ifdef CORE_BUS_STATS_EN
        checks++;
        if (got !== 32'h0001_0001) begin
            errors++; $display("FAIL stats_read: got %h want 00010001", got);
        end
`else
        checks++;
        if (got !== 32'h3333_4444) begin
            errors++; $display("FAIL ff_forwarded: got %h want 33334444", got);
        end
`endif
    endtask

    task automatic test_boundaries();
        core_result_i = {32'hA5A5_0001, 32'h5A5A_0002};
        run_cmd(8'h03, 24'h00001F, 32'h77, 0, 1'b0, 1'b0, dummy);
        run_cmd(8'h04, 24'h00000F, 32'h88, TMO - 1, 1'b1, 1'b0, dummy);
        run_cmd(8'h05, 24'h000010, 32'h99, TMO, 1'b0, 1'b0, dummy);
    endtask

    task automatic test_reset_during_wait();
        bit saw_rsp;
        cmd_valid_i = 1'b1; instruction_i = 8'h01; address_i = 24'h000005; value_i = 32'h42;
        @(posedge clk_i); @(negedge clk_i);
        cmd_valid_i = 1'b0;
        repeat (3) begin @(posedge clk_i); @(negedge clk_i); end
        rst_n = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        rst_n = 1'b1;
        model_reset();
        checks++;
        if ({cmd_ready_o, core_sel_o, rsp_valid_o, rsp_err_o, result_o, core_address_o} !== {1'b1, {NUM{1'b0}}, 58'h0}) begin
            errors++; $display("FAIL reset_in_wait_state: got ready=%b sel=%b rsp=%b res=%h ca=%h", cmd_ready_o, core_sel_o, rsp_valid_o, result_o, core_address_o);
        end
        saw_rsp = 1'b0;
        for (int i = 0; i < TMO + 5; i++) begin
            if (rsp_valid_o) saw_rsp = 1'b1;
            @(posedge clk_i); @(negedge clk_i);
        end
        checks++;
        if (saw_rsp) begin
            errors++; $display("FAIL abandoned_response: got response want none");
        end
        core_result_i[31:0] = 32'h0BAD_F00D;
        run_cmd(8'h01, 24'h000007, 32'h55, 0, 1'b0, 1'b0, dummy);
    endtask

    task automatic test_back_to_back();
        core_result_i = {32'h0000_1001, 32'h0000_2002};
        run_cmd(8'h11, 24'h000004, 32'hA, 1, 1'b0, 1'b1, dummy);
        run_cmd(8'h00, 24'h000014, 32'hB, 0, 1'b0, 1'b1, dummy);
        run_cmd(8'h12, 24'h000018, 32'hC, 0, 1'b0, 1'b1, dummy);
        run_cmd(8'h13, 24'h000030, 32'hD, 0, 1'b0, 1'b1, dummy);
        cmd_valid_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 1'b0 || core_sel_o !== '0) begin
            errors++; $display("FAIL b2b_quiet: got rsp=%b sel=%b want 0/0", rsp_valid_o, core_sel_o);
        end
    endtask

    task automatic test_random();
        logic [7:0]  ins;
        logic [23:0] addr;
        int          r;
        int          delay;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < NUM; k++) core_result_i[k*32 +: 32] = $urandom;
            r = int'($urandom_range(0, 9));
            ins = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
            r = int'($urandom_range(0, 8));
            if (r <= 4)      addr = 24'($urandom_range(0, NUM * (1 << SPAN) - 1));
            else if (r == 5) addr = 24'(NUM * (1 << SPAN));
            else if (r == 6) addr = 24'hFFFFFF;
            else if (r == 7) addr = 24'($urandom);
            else             addr = 24'(32'h0010_0000 | $urandom_range(0, 15));
            r = int'($urandom_range(0, 9));
            delay = (r == 0) ? -1 : (r == 1) ? TMO - 1 : int'($urandom_range(0, 6));
            run_cmd(ins, addr, $urandom, delay, 1'($urandom), 1'b0, dummy);
        end
    endtask

    initial begin
`ifdef CORE_BUS_STATS_EN
        stats_en = 1'b1;
`else
        stats_en = 1'b0;
`endif
        test_reset();
        test_mapped();
        test_unmapped();
        test_timeout();
        test_stats();
        test_boundaries();
        test_reset_during_wait();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
